// File: rtl/avl_mem_responder_if.sv
// avl_mem_responder_if
//   Avalon-MM command/response bundle between a requester (master) and the
//   RAM model (slave).
//   Command (master -> slave): avl_address, avl_read, avl_write, avl_writedata
//   Response (slave -> master): avl_wait, avl_readdatavalid, avl_readdata
//   Handshake: a command is taken at a rising edge where
//   (avl_read | avl_write) && !avl_wait. avl_wait depends on registered slave
//   state only, so the master may look at it before deciding what to drive.
//   avl_readdatavalid is a one-cycle strobe qualifying avl_readdata, with no
//   back-pressure on the return path.
interface avl_mem_responder_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] avl_address;
    logic              avl_read;
    logic              avl_write;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_wait;
    logic              avl_readdatavalid;
    logic [DATA_W-1:0] avl_readdata;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata,
        input  avl_wait, avl_readdatavalid, avl_readdata
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata,
        output avl_wait, avl_readdatavalid, avl_readdata
    );
endinterface

// File: rtl/avl_mem_responder.sv
// avl_mem_responder
//   Avalon-MM RAM model: word-addressed array with a fixed-latency read
//   pipeline, a cap on outstanding reads, and optional periodic stalls.
// Ports:
//   iCLK, iRST_n       clock, asynchronous active-low reset
//   avl (slave)        Avalon-MM command/response bundle
//   oob_err            sticky, an out-of-range command was accepted
//   proto_err          sticky, read and write were accepted together
//   rd_count/wr_count  accepted reads/writes, 16-bit wrapping
module avl_mem_responder #(
    parameter int RAM_ADDR_W  = 26,
    parameter int RAM_DATA_W  = 128,
    parameter int DEPTH_LOG2  = 10,
    parameter int RD_LAT      = 2,
    parameter int MAX_PEND    = 3,
    parameter int STALL_EVERY = 0,
    parameter logic [RAM_DATA_W-1:0] OOB_DATA = {(RAM_DATA_W/32){32'hDEAD_BEEF}}
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    avl_mem_responder_if.slave  avl,
    output logic                oob_err,
    output logic                proto_err,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int STALL_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

    // Backing store; deliberately not reset so contents survive iRST_n.
    logic [RAM_DATA_W-1:0] mem_q [DEPTH];

    logic [3:0]            pend_q, pend_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic                  stall_hit;
    logic [RD_LAT-1:0]     vld_q, vld_d;
    logic [RAM_DATA_W-1:0] dat_q [RD_LAT];
    logic [RAM_DATA_W-1:0] dat_d [RD_LAT];
    logic                  oob_q, oob_d, proto_q, proto_d;
    logic [15:0]           rdc_q, rdc_d, wrc_q, wrc_d;

    logic                  wait_w, cmd_acc, wr_acc, rd_acc, rd_ret, in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [RAM_DATA_W-1:0] rd_word;

    assign idx      = avl.avl_address[DEPTH_LOG2-1:0];
    assign in_range = ((avl.avl_address >> DEPTH_LOG2) == '0);

    generate
        if (STALL_EVERY != 0) begin : g_stall
            always_comb begin
                stall_hit = (stall_q == STALL_W'(STALL_EVERY - 1));
                stall_d   = stall_hit ? '0 : stall_q + 1'b1;
            end
        end else begin : g_nostall
            always_comb begin
                stall_hit = 1'b0;
                stall_d   = '0;
            end
        end
    endgenerate

    // Registered-state-only wait; held high throughout reset.
    assign wait_w = !iRST_n || (pend_q == 4'(MAX_PEND)) || stall_hit;

    always_comb begin
        cmd_acc = (avl.avl_read || avl.avl_write) && !wait_w;
        wr_acc  = cmd_acc && avl.avl_write;
        // A read that collides with a write is dropped.
        rd_acc  = cmd_acc && avl.avl_read && !avl.avl_write;
        rd_ret  = vld_q[RD_LAT-1];
        rd_word = in_range ? mem_q[idx] : OOB_DATA;

        // Data registers only load alongside a valid bit, so the last stage
        // keeps showing the most recently returned word between strobes.
        vld_d[0] = rd_acc;
        dat_d[0] = rd_acc ? rd_word : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end

        pend_d  = pend_q + {3'd0, rd_acc} - {3'd0, rd_ret};
        rdc_d   = rdc_q + {15'd0, rd_acc};
        wrc_d   = wrc_q + {15'd0, wr_acc};
        oob_d   = oob_q || (cmd_acc && !in_range);
        proto_d = proto_q || (cmd_acc && avl.avl_read && avl.avl_write);
    end

    always_ff @(posedge iCLK) begin
        if (wr_acc && in_range) begin
            mem_q[idx] <= avl.avl_writedata;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pend_q  <= '0;
            stall_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
            oob_q   <= 1'b0;
            proto_q <= 1'b0;
            rdc_q   <= '0;
            wrc_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            stall_q <= stall_d;
            vld_q   <= vld_d;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
            oob_q   <= oob_d;
            proto_q <= proto_d;
            rdc_q   <= rdc_d;
            wrc_q   <= wrc_d;
        end
    end

    assign avl.avl_wait          = wait_w;
    assign avl.avl_readdatavalid = vld_q[RD_LAT-1];
    assign avl.avl_readdata      = dat_q[RD_LAT-1];
    assign oob_err               = oob_q;
    assign proto_err             = proto_q;
    assign rd_count              = rdc_q;
    assign wr_count              = wrc_q;
endmodule

// File: tb/tb_avl_mem_responder.sv
// tb_avl_mem_responder
//   Three responders share one command bus; sel routes read/write strobes to
//   one of them and muxes its responses back:
//     u0: RD_LAT=2, MAX_PEND=3   u1: MAX_PEND=1   u2: STALL_EVERY=4
module tb_avl_mem_responder;
    localparam logic [127:0] OOB = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] V1  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic [25:0]  cmd_addr = '0;
    logic         cmd_rd = 1'b0;
    logic         cmd_wr = 1'b0;
    logic [127:0] cmd_wdata = '0;
    logic [127:0] cmd_exp = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] exp_q[$];
    int           ts_q[$];

    logic win = 1'b0;
    int   win_cyc, win_wait, win_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avl_mem_responder_if #(.ADDR_W(26), .DATA_W(128)) if0 ();
    avl_mem_responder_if #(.ADDR_W(26), .DATA_W(128)) if1 ();
    avl_mem_responder_if #(.ADDR_W(26), .DATA_W(128)) if2 ();

    logic        oob0, oob1, oob2, pro0, pro1, pro2;
    logic [15:0] rdc0, rdc1, rdc2, wrc0, wrc1, wrc2;

    assign if0.avl_address = cmd_addr;  assign if0.avl_writedata = cmd_wdata;
    assign if1.avl_address = cmd_addr;  assign if1.avl_writedata = cmd_wdata;
    assign if2.avl_address = cmd_addr;  assign if2.avl_writedata = cmd_wdata;
    assign if0.avl_read  = cmd_rd && (sel == 2'd0);
    assign if0.avl_write = cmd_wr && (sel == 2'd0);
    assign if1.avl_read  = cmd_rd && (sel == 2'd1);
    assign if1.avl_write = cmd_wr && (sel == 2'd1);
    assign if2.avl_read  = cmd_rd && (sel == 2'd2);
    assign if2.avl_write = cmd_wr && (sel == 2'd2);

    avl_mem_responder #(.RD_LAT(2), .MAX_PEND(3), .STALL_EVERY(0)) u0 (
        .iCLK(clk), .iRST_n(rst_n), .avl(if0),
        .oob_err(oob0), .proto_err(pro0), .rd_count(rdc0), .wr_count(wrc0));
    avl_mem_responder #(.RD_LAT(2), .MAX_PEND(1), .STALL_EVERY(0)) u1 (
        .iCLK(clk), .iRST_n(rst_n), .avl(if1),
        .oob_err(oob1), .proto_err(pro1), .rd_count(rdc1), .wr_count(wrc1));
    avl_mem_responder #(.RD_LAT(2), .MAX_PEND(3), .STALL_EVERY(4)) u2 (
        .iCLK(clk), .iRST_n(rst_n), .avl(if2),
        .oob_err(oob2), .proto_err(pro2), .rd_count(rdc2), .wr_count(wrc2));

    logic         m_wait, m_rdv, m_oob, m_proto;
    logic [127:0] m_rdata;
    logic [15:0]  m_rdc, m_wrc;

    always_comb begin
        m_wait = if0.avl_wait; m_rdv = if0.avl_readdatavalid; m_rdata = if0.avl_readdata;
        m_oob = oob0; m_proto = pro0; m_rdc = rdc0; m_wrc = wrc0;
        case (sel)
            2'd1: begin
                m_wait = if1.avl_wait; m_rdv = if1.avl_readdatavalid; m_rdata = if1.avl_readdata;
                m_oob = oob1; m_proto = pro1; m_rdc = rdc1; m_wrc = wrc1;
            end
            2'd2: begin
                m_wait = if2.avl_wait; m_rdv = if2.avl_readdatavalid; m_rdata = if2.avl_readdata;
                m_oob = oob2; m_proto = pro2; m_rdc = rdc2; m_wrc = wrc2;
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor/scoreboard: strobes pop the queue; an accept about to happen
    // at the coming edge pushes the expected word and its cycle stamp.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_rdv) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 128'd1, 128'd0);
                end else begin
                    logic [127:0] e;
                    int           t;
                    e = exp_q.pop_front();
                    t = ts_q.pop_front();
                    check_eq("rdata", m_rdata, e);
                    check_eq("latency", 128'(cyc - t), 128'd2);
                end
            end
            if (cmd_rd && !cmd_wr && !m_wait) begin
                exp_q.push_back(cmd_exp);
                ts_q.push_back(cyc);
            end
            if (win) begin
                win_cyc++;
                if (m_wait) win_wait++;
                if ((cmd_rd || cmd_wr) && !m_wait) win_acc++;
            end
        end
    end

    // Drive one command and hold it until accepted (bounded).
    task automatic do_cmd(input logic rd, input logic wr, input logic [25:0] a,
                          input logic [127:0] d, input logic [127:0] e);
        int guard = 0;
        cmd_rd = rd; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_exp = e;
        @(negedge clk);
        while (m_wait && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) check_eq("accept_timeout", 128'd1, 128'd0);
        @(posedge clk);
        #1;
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            g++;
            @(negedge clk);
        end
        check_eq("drain", 128'(exp_q.size()), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic win_start();
        win_cyc = 0; win_wait = 0; win_acc = 0;
        win = 1'b1;
    endtask

    initial begin
        int rc;
        logic [127:0] rnd [4];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wait", 128'(m_wait), 128'd1);
        check_eq("rst_rdv", 128'(m_rdv), 128'd0);
        check_eq("rst_rdata", m_rdata, 128'd0);
        check_eq("rst_flags", 128'({m_oob, m_proto}), 128'd0);
        check_eq("rst_cnt", 128'({m_rdc, m_wrc}), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("wait_after_rst", 128'(m_wait), 128'd0);
        @(posedge clk);
        #1;

        // Write then read back with latency check
        do_cmd(1'b0, 1'b1, 26'd5, V1, '0);
        do_cmd(1'b1, 1'b0, 26'd5, '0, V1);
        drain();
        check_eq("wr_count1", 128'(m_wrc), 128'd1);
        check_eq("rd_count1", 128'(m_rdc), 128'd1);

        // Random data at scattered addresses
        for (int i = 0; i < 4; i++) begin
            rnd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_cmd(1'b0, 1'b1, 26'(100 + 2*i + $urandom_range(0, 1)*0), rnd[i], '0);
        end
        for (int i = 3; i >= 0; i--) do_cmd(1'b1, 1'b0, 26'(100 + 2*i), '0, rnd[i]);
        drain();

        // Streaming reads on u0 and u1
        for (int s = 0; s < 2; s++) begin
            sel = 2'(s);
            for (int i = 0; i < 8; i++) do_cmd(1'b0, 1'b1, 26'(i), 128'(i * 16'h1111), '0);
            win_start();
            for (int i = 0; i < 8; i++) do_cmd(1'b1, 1'b0, 26'(i), '0, 128'(i * 16'h1111));
            win = 1'b0;
            check_eq("stream_acc", 128'(win_acc), 128'd8);
            check_eq("stream_wait", 128'(win_wait), (s == 0) ? 128'd0 : 128'd14);
            drain();
        end
        sel = 2'd0;

        // Out-of-range
        check_eq("oob_pre", 128'(m_oob), 128'd0);
        do_cmd(1'b0, 1'b1, 26'd3, 128'h33, '0);
        do_cmd(1'b1, 1'b0, 26'd1027, '0, OOB);
        drain();
        check_eq("oob_set", 128'(m_oob), 128'd1);
        do_cmd(1'b0, 1'b1, 26'd1027, {4{32'hFFFF_FFFF}}, '0);
        do_cmd(1'b1, 1'b0, 26'd3, '0, 128'h33);
        drain();

        // Read and write together
        check_eq("proto_pre", 128'(m_proto), 128'd0);
        rc = int'(m_rdc);
        do_cmd(1'b1, 1'b1, 26'd9, 128'hA5, '0);
        drain();
        check_eq("proto_set", 128'(m_proto), 128'd1);
        check_eq("proto_rdc", 128'(m_rdc), 128'(rc));
        do_cmd(1'b1, 1'b0, 26'd9, '0, 128'hA5);
        drain();

        // Periodic stall on u2
        sel = 2'd2;
        do_cmd(1'b0, 1'b1, 26'd4, 128'h4444_CAFE, '0);
        rc = int'(m_rdc);
        cmd_addr = 26'd4; cmd_exp = 128'h4444_CAFE; cmd_rd = 1'b1;
        win_start();
        repeat (40) @(posedge clk);
        #1;
        cmd_rd = 1'b0;
        win = 1'b0;
        check_eq("stall_wait", 128'(win_wait), 128'd10);
        check_eq("stall_acc", 128'(win_acc), 128'd30);
        drain();
        check_eq("stall_rdc", 128'(m_rdc), 128'(rc + 30));

        // Reset with reads in flight
        sel = 2'd0;
        do_cmd(1'b1, 1'b0, 26'd5, '0, 128'h5555);
        do_cmd(1'b1, 1'b0, 26'd5, '0, 128'h5555);
        rst_n = 1'b0;
        exp_q.delete();
        ts_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_rst_wait", 128'(m_wait), 128'd1);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_cnt", 128'({m_rdc, m_wrc}), 128'd0);
        check_eq("post_rst_flags", 128'({m_oob, m_proto}), 128'd0);
        check_eq("post_rst_rdata", m_rdata, 128'd0);
        repeat (6) @(posedge clk);
        #1;
        win_start();
        for (int i = 0; i < 3; i++) do_cmd(1'b1, 1'b0, 26'd5, '0, 128'h5555);
        win = 1'b0;
        check_eq("post_rst_wait", 128'(win_wait), 128'd0);
        drain();
        check_eq("post_rst_rdc", 128'(m_rdc), 128'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
